axim_rd_arbiter: RTL
====================

// Module: axim_rd_arbiter
// PURPOSE
//  Shares one AXI master read channel (AR + R) among C_NUM_REQ loaders
//  (load_bias, load_weight, load_ibuf). Round-robin grant per burst; one burst
//  outstanding at a time. R beats are routed to the owner until the burst is
//  complete. Sits between the loaders and the top-level maxi read port.
// PARAMETERS
//  C_NUM_REQ           3    number of requesters (2..8)
//  C_M_AXI_LEN_WIDTH   32   arlen width (AXI encoding: beats-1)
//  C_M_AXI_ADDR_WIDTH  32   araddr width
//  C_M_AXI_DATA_WIDTH  128  rdata width
// PORTS
//  I_clk          in   1      single clock
//  I_rst_n        in   1      asynchronous, active-low reset
//  I_req_arvalid  in   N      per-requester burst request
//  I_req_arlen    in   N*LEN  packed, requester i at [i*LEN +: LEN]
//  I_req_araddr   in   N*ADDR packed, same layout
//  O_req_arready  out  N      one-hot accept pulse to requester
//  I_req_rready   in   N      per-requester rready (loader's stable_rready)
//  O_req_rvalid   out  N      rvalid routed to owner only
//  O_req_rdata    out  DATA   rdata broadcast (qualify with O_req_rvalid)
//  O_req_rlast    out  N      last beat of owner's burst
//  O_maxi_arvalid out  1      to AXI
//  O_maxi_arlen   out  LEN
//  O_maxi_araddr  out  ADDR
//  I_maxi_arready in   1
//  O_maxi_rready  out  1
//  I_maxi_rvalid  in   1
//  I_maxi_rdata   in   DATA
//  O_busy         out  1      high in S_ADDR/S_DATA
// BEHAVIOUR
//  Reset: state S_IDLE, rr pointer 0, owner 0, beat count 0; all outputs 0.
//  S_IDLE: if any I_req_arvalid, pick first set bit at or after rr pointer
//   (wrapping); register owner, arlen, araddr; -> S_ADDR next cycle.
//  S_ADDR: O_maxi_arvalid=1 with registered arlen/araddr, held stable until
//   I_maxi_arready. On handshake: O_req_arready[owner] pulses 1 cycle; beat
//   count <= arlen; -> S_DATA.
//  S_DATA: O_maxi_rready = I_req_rready[owner]; O_req_rvalid[owner] =
//   I_maxi_rvalid (combinational, zero latency); rdata passes straight through.
//   Beat accepted when rvalid&rready. O_req_rlast[owner]=1 while count==0.
//   Last beat accepted -> rr pointer <= owner+1 (mod N) -> S_IDLE.
//  Grant latency: request to O_maxi_arvalid = 2 cycles (IDLE decide, ADDR).
//  Requester must hold arvalid/arlen/araddr until its O_req_arready pulse;
//   dropping arvalid before that is illegal (grant is not revoked).
//  Non-owners: O_req_arready, O_req_rvalid, O_req_rlast stay 0.
//  arlen=0: single-beat burst, rlast high on first beat.
//  Full-width arlen count uses LEN bits; no overflow (counts down).
//  Simultaneous requests: rr order guarantees each requester a grant within
//   N bursts; after owner i, priority is i+1, i+2, ... wrapping.
//  I_maxi_rvalid in S_IDLE/S_ADDR: ignored, O_maxi_rready=0.
//  Reset mid-burst: FSM to S_IDLE, outputs 0 immediately; AXI slave must
//   also be reset (no drain of outstanding beats).
// STRUCTURE
//  Shared package cnna_pkg: state encodings S_IDLE/S_ADDR/S_DATA,
//   C_NUM_REQ default, AXI width constants.
//  One sub-module: rr_pick (N-bit request + pointer -> one-hot grant and
//   index, combinational); FSM, counter and muxing in this module.
// TESTING
//  Single req0, arlen=3, addr 0x1000 -> AR after 2 cycles, 4 beats routed to
//   req0, rlast on beat 4, rr pointer=1.
//  req0,req1,req2 all asserted at once -> grants in order 0,1,2, then 0 again
//   if req0 re-requests.
//  arready held low 5 cycles -> arvalid/addr/len stable, no arready pulse
//   until handshake.
//  Owner rready toggles 1/0 every cycle, arlen=7 -> exactly 8 beats, none lost
//   or duplicated; maxi_rready tracks owner rready.
//  arlen=0 on req2 -> one beat with rlast=1, back to S_IDLE next cycle.
//  I_rst_n low during beat 2 of 4 -> all outputs 0 asynchronously,
//   S_IDLE after release, new request granted normally.

Source files
------------

// File: rtl/cnna_pkg.sv
// Shared definitions for the CNN accelerator memory-side blocks.
//  - arb_state_t : read-arbiter FSM encodings (S_IDLE/S_ADDR/S_DATA)
//  - default requester count and AXI master width constants
//  - idx_w       : index width for an N-entry one-hot (never below 1)
package cnna_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_t;

  localparam int C_NUM_REQ_DEF      = 3;
  localparam int C_AXI_LEN_WIDTH    = 32;
  localparam int C_AXI_ADDR_WIDTH   = 32;
  localparam int C_AXI_DATA_WIDTH   = 128;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker, purely combinational.
//  req   : N-bit request vector
//  ptr   : highest-priority index this round
//  grant : one-hot of the first set request at or after ptr (wrapping)
//  idx   : binary index of grant
//  any   : at least one request is set
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic          found;
  logic [IW:0]   pos;   // one extra bit so ptr+off cannot wrap before mod N
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    j     = '0;
    any   = |req;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, ptr} + (IW+1)'(off);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      j = pos[IW-1:0];
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/axim_rd_arbiter.sv
// Shares one AXI master read channel (AR + R) among C_NUM_REQ loaders.
// One burst outstanding; round-robin grant per burst; R beats routed to the
// burst owner until its last beat.
//  I_clk, I_rst_n          clock, async active-low reset
//  I_req_ar*/O_req_arready per-requester AR side (packed len/addr lanes)
//  I_req_rready            per-requester rready
//  O_req_rvalid/rlast      routed to owner only; O_req_rdata broadcast
//  O_maxi_*/I_maxi_*       shared AXI master read port
//  O_busy                  burst in flight (S_ADDR or S_DATA)
module axim_rd_arbiter
  import cnna_pkg::*;
#(
  parameter int C_NUM_REQ          = C_NUM_REQ_DEF,
  parameter int C_M_AXI_LEN_WIDTH  = C_AXI_LEN_WIDTH,
  parameter int C_M_AXI_ADDR_WIDTH = C_AXI_ADDR_WIDTH,
  parameter int C_M_AXI_DATA_WIDTH = C_AXI_DATA_WIDTH
) (
  input  logic                                      I_clk,
  input  logic                                      I_rst_n,
  input  logic [C_NUM_REQ-1:0]                      I_req_arvalid,
  input  logic [C_NUM_REQ*C_M_AXI_LEN_WIDTH-1:0]    I_req_arlen,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   I_req_araddr,
  output logic [C_NUM_REQ-1:0]                      O_req_arready,
  input  logic [C_NUM_REQ-1:0]                      I_req_rready,
  output logic [C_NUM_REQ-1:0]                      O_req_rvalid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]             O_req_rdata,
  output logic [C_NUM_REQ-1:0]                      O_req_rlast,
  output logic                                      O_maxi_arvalid,
  output logic [C_M_AXI_LEN_WIDTH-1:0]              O_maxi_arlen,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             O_maxi_araddr,
  input  logic                                      I_maxi_arready,
  output logic                                      O_maxi_rready,
  input  logic                                      I_maxi_rvalid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]             I_maxi_rdata,
  output logic                                      O_busy
);

  localparam int LW = C_M_AXI_LEN_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int IW = idx_w(C_NUM_REQ);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, owner_q, nxt_ptr;
  logic [LW-1:0] len_q, cnt_q, sel_len;
  logic [AW-1:0] addr_q, sel_addr;

  logic [C_NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic in_addr, in_data, own_rready, beat, last_beat;

  rr_pick #(.N(C_NUM_REQ), .IW(IW)) u_pick (
    .req   (I_req_arvalid),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // AND-OR mux of the winning lane's len/addr
  always_comb begin
    sel_len  = '0;
    sel_addr = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      sel_len  = sel_len  | (I_req_arlen[i*LW +: LW]  & {LW{pick_oh[i]}});
      sel_addr = sel_addr | (I_req_araddr[i*AW +: AW] & {AW{pick_oh[i]}});
    end
  end

  assign in_addr    = (state_q == S_ADDR);
  assign in_data    = (state_q == S_DATA);
  assign own_rready = I_req_rready[owner_q];
  assign beat       = in_data & I_maxi_rvalid & own_rready;
  assign last_beat  = beat & (cnt_q == '0);
  assign nxt_ptr    = (owner_q == IW'(C_NUM_REQ-1)) ? '0 : owner_q + IW'(1);

  // FSM state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_any)       state_d = S_ADDR;
      S_ADDR:  if (I_maxi_arready) state_d = S_DATA;
      S_DATA:  if (last_beat)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Burst context: owner/len/addr latched at decision, counter loaded at AR
  // handshake and counted down so full-width arlen never overflows.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == S_IDLE && pick_any) begin
        owner_q <= pick_idx;
        len_q   <= sel_len;
        addr_q  <= sel_addr;
      end
      if (in_addr && I_maxi_arready) cnt_q <= len_q;
      if (beat) begin
        if (cnt_q == '0) ptr_q <= nxt_ptr;
        else             cnt_q <= cnt_q - LW'(1);
      end
    end
  end

  // Outputs decode from state, so an async reset clears them immediately.
  always_comb begin
    O_req_arready = '0;
    O_req_rvalid  = '0;
    O_req_rlast   = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        O_req_arready[i] = in_addr & I_maxi_arready;
        O_req_rvalid[i]  = in_data & I_maxi_rvalid;
        O_req_rlast[i]   = in_data & (cnt_q == '0);
      end
    end
  end

  assign O_req_rdata    = in_data ? I_maxi_rdata : '0;
  assign O_maxi_arvalid = in_addr;
  assign O_maxi_arlen   = in_addr ? len_q  : '0;
  assign O_maxi_araddr  = in_addr ? addr_q : '0;
  assign O_maxi_rready  = in_data & own_rready;
  assign O_busy         = (state_q != S_IDLE);

endmodule
